perspective_divide: RTL
=======================

PERSPECTIVE_DIVIDE -- requirements
Module: perspective_divide

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DATAWIDTH, default 18: signed fixed-point word width.
REQ-003 Parameter FRACBITS, default 12: number of fractional bits.
REQ-004 Derived constant DIVBITS SHALL equal 2*FRACBITS+1.
REQ-005 Port clk, input, 1 bit: clock.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port i_v[4], input, 4 x DATAWIDTH signed: homogeneous clip-space vector (x, y, z, w), matching the transform pipeline's output.
REQ-008 Port i_dv, input, 1 bit: i_v is valid.
REQ-009 Port o_ready, output, 1 bit: a vector can be accepted this cycle; it drives the upstream pipeline enable.
REQ-010 Port o_ndc[3], output, 3 x DATAWIDTH signed: x/w, y/w, z/w.
REQ-011 Port o_clip, output, 1 bit: the vector had w <= 0 and o_ndc is forced to zero.
REQ-012 Port o_sat, output, 1 bit: the reciprocal or at least one o_ndc lane was saturated.
REQ-013 Port o_dv, output, 1 bit: o_ndc, o_clip and o_sat are valid.
REQ-014 Port i_ready, input, 1 bit: downstream accepts the output.

Function
REQ-015 The FSM SHALL have four states: IDLE, DIVIDE, SCALE and OUTPUT.
REQ-016 o_ready SHALL be 1 only in IDLE while rst is low, with o_ready=1 and i_dv=1 on the same edge meaning acceptance.
REQ-017 In IDLE, i_dv SHALL be ignored when o_ready=0, leaving the upstream to hold its data.
REQ-018 On acceptance, i_v SHALL be captured and the block SHALL go to DIVIDE if w > 0, otherwise to OUTPUT with o_clip=1, o_sat=0 and o_ndc all zero.
REQ-019 DIVIDE SHALL run a restoring unsigned division of 2^(2*FRACBITS) by w, producing one quotient bit per cycle, for exactly DIVBITS cycles, then go to SCALE.
REQ-020 The reciprocal SHALL be the floor quotient, saturated to 2^(DATAWIDTH-1)-1 if it exceeds that, with saturation setting the o_sat flag.
REQ-021 SCALE SHALL take one cycle: each lane = (coord * recip) arithmetically shifted right by FRACBITS, with the product held at full 2*DATAWIDTH width, then go to OUTPUT.
REQ-022 Each lane result outside the signed DATAWIDTH range SHALL clamp to max or min and set o_sat.
REQ-023 In OUTPUT, o_dv SHALL be 1 and o_ndc, o_clip and o_sat SHALL be held stable until an edge with i_ready=1, after which the FSM goes to IDLE.
REQ-024 Latency on the non-clip path SHALL be: o_dv first high DIVBITS+2 cycles after the accepting edge (27 at defaults).
REQ-025 Latency on the clip path SHALL be: o_dv first high 1 cycle after the accepting edge.
REQ-026 When o_dv is low, o_ndc, o_clip and o_sat SHALL keep their last values, and o_dv SHALL never be high outside OUTPUT.
REQ-027 Throughput SHALL be one vector per acceptance, with no acceptance in DIVIDE, SCALE or OUTPUT.

Reset
REQ-028 While rst=1 at an edge, the FSM SHALL go to IDLE, and o_dv, o_clip, o_sat, o_ndc, the captured vector and the divider state SHALL become 0.
REQ-029 o_ready SHALL be 0 during any cycle in which rst is sampled high.
REQ-030 Reset asserted mid-DIVIDE or mid-OUTPUT SHALL abort the operation with no o_dv pulse afterward; o_ready SHALL be 1 on the first cycle after rst drops.

Structure
REQ-031 The FSM state enum and the fixed-point helper constants (ONE = 2^FRACBITS, saturation limits) SHALL live in the shared math package.
REQ-032 The iterative divider SHALL be a sub-module named fixed_recip, with start/done handshake, DIVBITS-cycle latency and a saturation flag.
REQ-033 The top-level module SHALL contain only the FSM, the capture registers, the SCALE multiply and the output registers.

Verification
REQ-034 Basic divide: i_v=(4096,-8192,2048,8192) [1,-2,0.5,w=2], i_ready=1 -> o_ndc=(2048,-4096,1024), o_clip=0, o_sat=0, o_dv 27 cycles after acceptance.
REQ-035 Small w: w=2048 [0.5], x=12288 [3.0] -> o_ndc[0]=24576 [6.0], o_sat=0.
REQ-036 Clip path: w=-4096 and w=0 -> o_clip=1, o_ndc=0, o_dv 1 cycle after acceptance, no DIVIDE cycles.
REQ-037 Saturation: w=1 raw, x=4096, y=-4096 -> recip clamps to 131071, o_ndc[0]=131071, o_ndc[1]=-131071, o_sat=1.
REQ-038 Backpressure: hold i_ready=0 for 10 cycles in OUTPUT -> o_dv and o_ndc stable, o_ready=0, a second i_dv vector is not accepted until one cycle after i_ready=1.
REQ-039 Reset mid-DIVIDE: assert rst at cycle 5 of DIVIDE -> no o_dv pulse, o_ready=1 the cycle after rst drops, and the next vector computes correctly.

Source files
------------

// File: rtl/perspective_divide_pkg.sv
// Shared fixed-point helpers and FSM encoding for the perspective divide block.
// Helpers are width-parameterised so overridden DATAWIDTH/FRACBITS stay consistent.
package perspective_divide_pkg;

  localparam int PD_DATAWIDTH = 18;
  localparam int PD_FRACBITS  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } pd_state_e;

  // ONE = 2^fb in a word with fb fractional bits
  function automatic longint fx_one(input int fb);
    return longint'(1) << fb;
  endfunction

  function automatic longint fx_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint fx_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/fixed_recip.sv
// Iterative restoring divider: floor(2^(2*FRACBITS) / divisor), one quotient bit per cycle.
// start loads the operands; done marks the edge that retires the last of DIVBITS steps.
module fixed_recip
  import perspective_divide_pkg::*;
#(
  parameter int DATAWIDTH = PD_DATAWIDTH,
  parameter int FRACBITS  = PD_FRACBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 done,
  output logic [DATAWIDTH-1:0] recip,
  output logic                 sat
);

  localparam int DIVBITS = 2 * FRACBITS + 1;
  localparam int CW      = $clog2(DIVBITS);
  localparam logic [DIVBITS-1:0] DIVIDEND  = DIVBITS'(fx_one(FRACBITS) * fx_one(FRACBITS));
  localparam logic [DIVBITS-1:0] RECIP_MAX = DIVBITS'(fx_max(DATAWIDTH));

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] div_q, div_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [DIVBITS-1:0]   num_q, num_d;
  logic [DIVBITS-1:0]   quo_q, quo_d;
  logic [DATAWIDTH:0]   rem_sh, trial;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    rem_d  = rem_q;
    num_d  = num_q;
    quo_d  = quo_q;
    done   = 1'b0;
    rem_sh = {rem_q, num_q[DIVBITS-1]};
    // divisor < 2^(DATAWIDTH-1), so the top bit of trial is a clean borrow flag
    trial  = rem_sh - {1'b0, div_q};
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = divisor;
      rem_d  = '0;
      num_d  = DIVIDEND;
      quo_d  = '0;
    end else if (busy_q) begin
      num_d = num_q << 1;
      if (!trial[DATAWIDTH]) begin
        rem_d = trial[DATAWIDTH-1:0];
        quo_d = {quo_q[DIVBITS-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DATAWIDTH-1:0];
        quo_d = {quo_q[DIVBITS-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DIVBITS - 1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= '0;
      rem_q  <= '0;
      num_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      rem_q  <= rem_d;
      num_q  <= num_d;
      quo_q  <= quo_d;
    end
  end

  assign sat   = (quo_q > RECIP_MAX);
  assign recip = sat ? RECIP_MAX[DATAWIDTH-1:0] : quo_q[DATAWIDTH-1:0];

endmodule

// File: rtl/perspective_divide.sv
// Perspective divide: (x,y,z)/w via an iterative reciprocal then one scaling multiply.
// One vector in flight; o_ready only in IDLE, result held in OUTPUT until i_ready.
module perspective_divide
  import perspective_divide_pkg::*;
#(
  parameter int DATAWIDTH = PD_DATAWIDTH,
  parameter int FRACBITS  = PD_FRACBITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATAWIDTH-1:0] i_v [4],
  input  logic                        i_dv,
  output logic                        o_ready,
  output logic signed [DATAWIDTH-1:0] o_ndc [3],
  output logic                        o_clip,
  output logic                        o_sat,
  output logic                        o_dv,
  input  logic                        i_ready
);

  localparam logic signed [2*DATAWIDTH-1:0] LANE_MAX = (2*DATAWIDTH)'(fx_max(DATAWIDTH));
  localparam logic signed [2*DATAWIDTH-1:0] LANE_MIN = (2*DATAWIDTH)'(fx_min(DATAWIDTH));
  localparam logic signed [DATAWIDTH-1:0]   OUT_MAX  = DATAWIDTH'(fx_max(DATAWIDTH));
  localparam logic signed [DATAWIDTH-1:0]   OUT_MIN  = DATAWIDTH'(fx_min(DATAWIDTH));

  pd_state_e                  state_q, state_d;
  logic signed [DATAWIDTH-1:0] v_q [3];
  logic signed [DATAWIDTH-1:0] v_d [3];
  logic signed [DATAWIDTH-1:0] ndc_q [3];
  logic signed [DATAWIDTH-1:0] ndc_d [3];
  logic                        clip_q, clip_d;
  logic                        sat_q, sat_d;

  logic                        div_start, div_done, recip_sat;
  logic [DATAWIDTH-1:0]        recip;
  logic signed [DATAWIDTH-1:0] lane [3];
  logic                        lane_sat;
  logic signed [2*DATAWIDTH-1:0] coord_ext, recip_ext, prod, shifted;

  // w is held inside the divider, so only x/y/z are captured here
  fixed_recip #(
    .DATAWIDTH(DATAWIDTH),
    .FRACBITS (FRACBITS)
  ) u_recip (
    .clk    (clk),
    .rst    (rst),
    .start  (div_start),
    .divisor(i_v[3]),
    .done   (div_done),
    .recip  (recip),
    .sat    (recip_sat)
  );

  always_comb begin
    lane_sat  = 1'b0;
    coord_ext = '0;
    recip_ext = {{DATAWIDTH{1'b0}}, recip};
    prod      = '0;
    shifted   = '0;
    lane      = '{default: '0};
    for (int i = 0; i < 3; i++) begin
      coord_ext = v_q[i];
      prod      = coord_ext * recip_ext;
      shifted   = prod >>> FRACBITS;
      if (shifted > LANE_MAX) begin
        lane[i]  = OUT_MAX;
        lane_sat = 1'b1;
      end else if (shifted < LANE_MIN) begin
        lane[i]  = OUT_MIN;
        lane_sat = 1'b1;
      end else begin
        lane[i] = shifted[DATAWIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    ndc_d     = ndc_q;
    clip_d    = clip_q;
    sat_d     = sat_q;
    div_start = 1'b0;
    o_ready   = (state_q == IDLE) && !rst;
    o_dv      = (state_q == OUTPUT);
    case (state_q)
      IDLE: begin
        if (o_ready && i_dv) begin
          for (int i = 0; i < 3; i++) v_d[i] = i_v[i];
          if (i_v[3] > 0) begin
            state_d   = DIVIDE;
            div_start = 1'b1;
          end else begin
            state_d = OUTPUT;
            ndc_d   = '{default: '0};
            clip_d  = 1'b1;
            sat_d   = 1'b0;
          end
        end
      end
      DIVIDE: if (div_done) state_d = SCALE;
      SCALE: begin
        ndc_d   = lane;
        clip_d  = 1'b0;
        sat_d   = recip_sat | lane_sat;
        state_d = OUTPUT;
      end
      OUTPUT: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '{default: '0};
      ndc_q   <= '{default: '0};
      clip_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      ndc_q   <= ndc_d;
      clip_q  <= clip_d;
      sat_q   <= sat_d;
    end
  end

  assign o_ndc  = ndc_q;
  assign o_clip = clip_q;
  assign o_sat  = sat_q;

endmodule
